// File: rtl/lutram_sweep_checker_pkg.sv
// Shared types and constants for the LUTRAM sweep checker.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package lutram_sweep_checker_pkg;

  // Sweep sequencer states. CHK_* compare read data; WR_* write every word.
  typedef enum logic [2:0] {
    IDLE,
    CHK_INIT,
    WR_INV,
    CHK_INV,
    WR_RESTORE,
    DONE
  } state_t;

  // Values of the MODE parameter.
  localparam int MODE_INIT_ONLY = 0;  // check against INIT only
  localparam int MODE_MARCH     = 1;  // INIT check, inverse march, restore

  // The mismatch counter holds at this value instead of wrapping.
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lutram_sweep_checker_chan.sv
// One DEPTH x 1 LUTRAM channel: asynchronous read, synchronous write, preloaded from INIT.
// Latency: read is combinational from addr; a write lands on the next rising clk edge.
// Backpressure: none; a write is accepted on every cycle that we is high.
// Ports: clk (write clock), we (write enable), addr (word address),
//        wdata (write bit), rdata (read bit at addr).
module lutram_chan #(
  parameter int              DEPTH = 64,
  parameter logic [DEPTH-1:0] INIT = '0,
  localparam int             AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          wdata,
  output logic          rdata
);

  // Power-up contents come from INIT. There is deliberately no reset here,
  // so a sweep that is interrupted leaves its partial writes in place.
  logic [DEPTH-1:0] mem = INIT;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/lutram_sweep_checker.sv
// Self-test sweep over CHANNELS x DEPTH LUTRAM: INIT check, then optionally an inverse march and a restore.
// Latency: done_o rises DEPTH+1 cycles after the start pulse (MODE 0), or 4*DEPTH+1 cycles after it (MODE 1).
// Backpressure: start_i is ignored while busy_o is high; a sweep, once started, always runs to completion.
// Ports: clk_i/rst_ni (clock, async active-low reset); start_i (start pulse); inj_i (inject one
//        fault, sampled at start); busy_o/done_o (status); fail_o, err_addr_o, err_chan_o,
//        err_cnt_o (result of the most recent sweep).
module lutram_sweep_checker
  import lutram_sweep_checker_pkg::*;
#(
  parameter int                         DEPTH    = 64,
  parameter int                         CHANNELS = 4,
  parameter logic [DEPTH*CHANNELS-1:0]  INIT     = {(DEPTH*CHANNELS/32){32'hDEADBEEF}},
  parameter int                         MODE     = MODE_MARCH
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       inj_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       fail_o,
  output logic [7:0] err_addr_o,
  output logic [2:0] err_chan_o,
  output logic [7:0] err_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  state_t              state;
  logic [AW-1:0]       addr;
  logic                inj_lat;
  logic                last_addr;
  logic                wr_en;
  logic [CHANNELS-1:0] rdata;
  logic [CHANNELS-1:0] init_bits;
  logic [CHANNELS-1:0] wdata;
  logic [CHANNELS-1:0] miss;
  logic [2:0]          first_chan;
  state_t              nxt;

  assign last_addr = (addr == AW'(DEPTH - 1));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    localparam logic [DEPTH-1:0] CH_INIT = INIT[c*DEPTH +: DEPTH];

    // Reference bit for this channel at the current address.
    assign init_bits[c] = CH_INIT[addr];

    lutram_chan #(
      .DEPTH (DEPTH),
      .INIT  (CH_INIT)
    ) u_chan (
      .clk   (clk_i),
      .we    (wr_en),
      .addr  (addr),
      .wdata (wdata[c]),
      .rdata (rdata[c])
    );
  end

  // State that follows a sweep state once its last address has been handled.
  function automatic state_t next_sweep(input state_t s);
    case (s)
      CHK_INIT: next_sweep = (MODE == MODE_INIT_ONLY) ? DONE : WR_INV;
      WR_INV:   next_sweep = CHK_INV;
      CHK_INV:  next_sweep = WR_RESTORE;
      default:  next_sweep = DONE;
    endcase
  endfunction

  assign nxt = next_sweep(state);

  always_comb begin
    wr_en = (state == WR_INV) || (state == WR_RESTORE);
    wdata = (state == WR_INV) ? ~init_bits : init_bits;
    // Fault injection: channel 0, word 0 keeps its INIT value through the
    // inverse write, so CHK_INV finds exactly one mismatching word.
    if ((state == WR_INV) && inj_lat && (addr == '0)) begin
      wdata[0] = init_bits[0];
    end

    miss = '0;
    if (state == CHK_INIT) begin
      miss = rdata ^ init_bits;
    end else if (state == CHK_INV) begin
      miss = rdata ^ ~init_bits;
    end

    // Scan downwards so that the lowest mismatching channel is the one kept.
    first_chan = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (miss[c]) begin
        first_chan = 3'(c);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      addr       <= '0;
      inj_lat    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      fail_o     <= 1'b0;
      err_addr_o <= '0;
      err_chan_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state      <= CHK_INIT;
            addr       <= '0;
            inj_lat    <= inj_i;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            fail_o     <= 1'b0;
            err_addr_o <= '0;
            err_chan_o <= '0;
            err_cnt_o  <= '0;
          end
        end
        CHK_INIT, WR_INV, CHK_INV, WR_RESTORE: begin
          // A word counts once, however many of its channels disagree.
          if (|miss) begin
            fail_o    <= 1'b1;
            err_cnt_o <= sat_inc(err_cnt_o);
            // fail_o still low means this is the first bad word of the sweep.
            if (!fail_o) begin
              err_addr_o <= 8'(addr);
              err_chan_o <= first_chan;
            end
          end
          if (last_addr) begin
            addr   <= '0;
            state  <= nxt;
            busy_o <= (nxt != DONE);
            done_o <= (nxt == DONE);
          end else begin
            addr <= addr + AW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          addr   <= '0;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lutram_sweep_checker.sv
// Bench for lutram_sweep_checker: three configurations driven by directed sweeps.
// Latency: each sweep's expected result goes into a scoreboard queue; a monitor compares it on the rising edge of done_o.
// Backpressure: n/a; a start pulse issued while a sweep is running is expected to be ignored.
module tb_lutram_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic [2:0] start = '0;
  logic [2:0] inj   = '0;
  logic [2:0] busy, done, fail;
  logic [7:0] eaddr [3];
  logic [2:0] echan [3];
  logic [7:0] ecnt  [3];

  // dut0: default configuration; dut1: INIT check only; dut2: largest size, all-zero INIT.
  lutram_sweep_checker dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .inj_i(inj[0]),
    .busy_o(busy[0]), .done_o(done[0]), .fail_o(fail[0]),
    .err_addr_o(eaddr[0]), .err_chan_o(echan[0]), .err_cnt_o(ecnt[0]));

  lutram_sweep_checker #(.DEPTH(32), .CHANNELS(4), .MODE(0)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .inj_i(inj[1]),
    .busy_o(busy[1]), .done_o(done[1]), .fail_o(fail[1]),
    .err_addr_o(eaddr[1]), .err_chan_o(echan[1]), .err_cnt_o(ecnt[1]));

  lutram_sweep_checker #(.DEPTH(256), .CHANNELS(8), .INIT('0), .MODE(1)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .inj_i(inj[2]),
    .busy_o(busy[2]), .done_o(done[2]), .fail_o(fail[2]),
    .err_addr_o(eaddr[2]), .err_chan_o(echan[2]), .err_cnt_o(ecnt[2]));

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         id;
    int         t0;
    int         lat;
    int         busy_cyc;
    logic       fail;
    logic [7:0] addr;
    logic [2:0] chan;
    logic [7:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [2:0] done_q = '0;
  int         busy_cnt [3] = '{0, 0, 0};
  int         wr_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        busy_cnt[i] = 0;
      end else if (busy[i] === 1'b1) begin
        busy_cnt[i]++;
      end
      if (done[i] === 1'b1 && !done_q[i]) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: dut%0d raised done, expected no sweep", i);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("dut_id(dut%0d)", i), i, e.id);
          chk($sformatf("latency(dut%0d)", i), cyc - e.t0, e.lat);
          chk($sformatf("busy_cycles(dut%0d)", i), busy_cnt[i], e.busy_cyc);
          chk($sformatf("fail(dut%0d)", i), fail[i], e.fail);
          chk($sformatf("err_addr(dut%0d)", i), eaddr[i], e.addr);
          chk($sformatf("err_chan(dut%0d)", i), echan[i], e.chan);
          chk($sformatf("err_cnt(dut%0d)", i), ecnt[i], e.cnt);
        end
        busy_cnt[i] = 0;
      end
      done_q[i] = (done[i] === 1'b1);
    end
    if (dut1.wr_en === 1'b1) wr_cnt++;
  end

  // Large configuration: every state change inside a sweep must follow address 255 and land on 0.
  logic [2:0] st_q   = '0;
  logic [7:0] ad_q   = '0;
  logic       busy_q = 1'b0;
  always @(negedge clk) begin
    if (rst_n && busy_q && (dut2.state != st_q)) begin
      chk("big_wrap_prev_addr", ad_q, 255);
      chk("big_wrap_new_addr", dut2.addr, 0);
    end
    st_q   = dut2.state;
    ad_q   = dut2.addr;
    busy_q = (busy[2] === 1'b1);
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int id, input bit inj_v, input int lat, input int bcyc,
                       input bit f, input int a, input int ch, input int n);
    exp_t e;
    @(negedge clk);
    start[id] = 1'b1;
    inj[id]   = inj_v;
    e.id = id; e.t0 = cyc; e.lat = lat; e.busy_cyc = bcyc;
    e.fail = f; e.addr = 8'(a); e.chan = 3'(ch); e.cnt = 8'(n);
    sbq.push_back(e);
    @(negedge clk);
    start[id] = 1'b0;
    inj[id]   = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (sbq.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout_%s: %0d sweeps still pending, expected 0", name, sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy[0], 0);
    chk({tag, "_done"}, done[0], 0);
    chk({tag, "_fail"}, fail[0], 0);
    chk({tag, "_err_addr"}, eaddr[0], 0);
    chk({tag, "_err_chan"}, echan[0], 0);
    chk({tag, "_err_cnt"}, ecnt[0], 0);
  endtask

  initial begin
    int t;
    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Clean sweep, then an injected fault, then a clean sweep with a stray start mid-way.
    issue(0, 1'b0, 257, 256, 1'b0, 0, 0, 0);
    wait_drain("clean", 2000);
    issue(0, 1'b1, 257, 256, 1'b1, 0, 0, 1);
    wait_drain("inject", 2000);
    issue(0, 1'b0, 257, 256, 1'b0, 0, 0, 0);
    repeat (100) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_drain("busy_start", 2000);

    // Abort during WR_INV at address 10: words 0..9 are left inverted in every channel.
    @(negedge clk);
    start[0] = 1'b1;
    t = cyc;
    @(negedge clk);
    start[0] = 1'b0;
    while (cyc < t + 75) @(negedge clk);
    chk("abort_point_addr", dut0.addr, 10);
    rst_n = 1'b0;
    #1 chk_zero("abort_reset");
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 1'b0, 257, 256, 1'b1, 0, 0, 10);
    wait_drain("after_abort", 2000);
    issue(0, 1'b0, 257, 256, 1'b0, 0, 0, 0);
    wait_drain("repaired", 2000);

    // INIT-check-only configuration: 32 busy cycles and no writes at all.
    wr_cnt = 0;
    issue(1, 1'b0, 33, 32, 1'b0, 0, 0, 0);
    wait_drain("mode0", 500);
    chk("mode0_write_cycles", wr_cnt, 0);

    // Largest configuration with all-zero INIT.
    issue(2, 1'b0, 1025, 1024, 1'b0, 0, 0, 0);
    wait_drain("big", 3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
